// File: rtl/tomasulo_icache_pkg.sv
// Shared types and line geometry for the direct-mapped instruction cache.
package tomasulo_icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESPOND
    } icache_state_t;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = $clog2(LINE_BYTES);

    typedef logic [127:0] line_t;

endpackage

// File: rtl/tomasulo_icache_array.sv
// Valid/tag/data storage for the instruction cache: one synchronous read port,
// one write port, and a bulk valid clear.
module tomasulo_icache_array
    import tomasulo_icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 24,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             valid_clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output line_t            rd_line,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  line_t            wr_line
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    line_t            data_mem [LINES];

    always_ff @(posedge clk) begin
        if (valid_clr) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
        rd_valid <= valid_q[rd_idx];
        rd_tag   <= tag_mem[rd_idx];
        rd_line  <= data_mem[rd_idx];
    end

endmodule

// File: rtl/tomasulo_icache.sv
// Direct-mapped instruction cache: 128-bit fetch lines refilled over a 32-bit
// req/ack memory port. Define TOMASULO_ICACHE_STATS_EN to add hit/miss counters.
//
// state   | meaning
// IDLE    | accepting fetches; a lookup result appears the cycle after accept
// REFILL  | bursting four words from backing memory into the fill buffer
// RESPOND | one-cycle return of the refilled line (suppressed if aborted)
module tomasulo_icache
    import tomasulo_icache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd_en,
    input  logic              cpu_abort,
    output line_t             cpu_data,
    output logic              cpu_valid,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [31:0]       mem_data,
    input  logic              mem_ack
`ifdef TOMASULO_ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IDX_W   = $clog2(LINES);
    localparam int LADDR_W = ADDR_W - OFFSET_W;
    localparam int TAG_W   = LADDR_W - IDX_W;

    icache_state_t      state_q;
    logic [LADDR_W-1:0] addr_q;
    logic               look_q;
    logic               drop_q;
    logic [1:0]         beat_q;
    logic [1:0]         beat_nxt;
    logic [31:0]        fill_q [WORDS_PER_LINE];
    line_t              data_q;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    line_t              rd_line;

    logic               tag_hit;
    logic               hit_now;
    logic               miss_now;
    logic               hit_valid;
    logic               resp_valid;
    logic               accept;
    logic               beat_ack;
    logic               final_ack;
    line_t              fill_line;
    line_t              wr_line;

    wire unused_offset = ^cpu_addr[OFFSET_W-1:0];

    tomasulo_icache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .valid_clr (~rst),
        .rd_idx    (cpu_addr[OFFSET_W +: IDX_W]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .we        (final_ack & rst),
        .wr_idx    (addr_q[IDX_W-1:0]),
        .wr_tag    (addr_q[LADDR_W-1:IDX_W]),
        .wr_line   (wr_line)
    );

    // The array read issued on accept lands one cycle later, lined up with look_q.
    always_comb begin
        tag_hit    = rd_valid && (rd_tag == addr_q[LADDR_W-1:IDX_W]);
        hit_now    = look_q && tag_hit;
        miss_now   = look_q && !tag_hit;
        hit_valid  = hit_now && !cpu_abort;
        resp_valid = (state_q == RESPOND) && !drop_q && !cpu_abort;
        accept     = (state_q == IDLE) && cpu_rd_en && !cpu_abort && !miss_now;
        beat_ack   = (state_q == REFILL) && mem_req && mem_ack;
        final_ack  = beat_ack && (beat_q == 2'd3);
        beat_nxt   = beat_q + 2'd1;
        fill_line  = {fill_q[3], fill_q[2], fill_q[1], fill_q[0]};
        wr_line    = {mem_data, fill_q[2], fill_q[1], fill_q[0]};
        cpu_valid  = hit_valid || resp_valid;
        cpu_busy   = (state_q == REFILL) || miss_now;
        if (hit_valid) begin
            cpu_data = rd_line;
        end else if (resp_valid) begin
            cpu_data = fill_line;
        end else begin
            cpu_data = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            look_q   <= 1'b0;
            drop_q   <= 1'b0;
            beat_q   <= 2'd0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            data_q   <= '0;
        end else begin
            data_q <= cpu_data;
            look_q <= accept;
            if (accept) begin
                addr_q <= cpu_addr[ADDR_W-1:OFFSET_W];
            end
            case (state_q)
                IDLE: begin
                    if (miss_now) begin
                        state_q  <= REFILL;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr_q, 2'd0, 2'b00};
                        beat_q   <= 2'd0;
                        drop_q   <= cpu_abort;
                    end
                end
                REFILL: begin
                    if (cpu_abort) begin
                        drop_q <= 1'b1;
                    end
                    if (beat_ack) begin
                        if (final_ack) begin
                            state_q <= RESPOND;
                            mem_req <= 1'b0;
                            beat_q  <= 2'd0;
                        end else begin
                            beat_q   <= beat_nxt;
                            mem_addr <= {addr_q, beat_nxt, 2'b00};
                        end
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    drop_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat_ack) begin
            fill_q[beat_q] <= mem_data;
        end
    end

`ifdef TOMASULO_ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_now && !cpu_abort) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_now && !cpu_abort) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/tomasulo_icache.md
Name: tomasulo_icache

Overview:
- Direct-mapped instruction cache between the CPU program-memory port (p_mem_add / p_mem_data, 128-bit fetch line) and a narrow 32-bit backing program memory.
- Serves one 4-instruction line per request with a registered valid flag; the front end uses this flag in place of its tied-high d_valid.
- On a miss, refills the line with a 4-beat req/ack burst.
- Honours front-end abort so a flushed fetch never returns stale data.

Parameters:
- LINES, 16, number of cache lines; power of two, >= 2. IDX_W = log2(LINES).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- cpu_addr  in  ADDR_W  fetch byte address; bits [3:0] ignored.
- cpu_rd_en  in  1  fetch request, sampled in IDLE only.
- cpu_abort  in  1  front-end flush; cancels any outstanding response.
- cpu_data  out  128  fetched line; word0 (lowest address) in [31:0], word3 in [127:96].
- cpu_valid  out  1  one-cycle pulse; cpu_data valid.
- cpu_busy  out  1  high while a refill is in progress; the CPU must hold its request.
- mem_addr  out  ADDR_W  backing-memory word address {line_addr, beat, 2'b00}.
- mem_req  out  1  backing-memory read request.
- mem_data  in  32  backing-memory read data.
- mem_ack  in  1  mem_data valid; completes one beat.

Behaviour:
- Address split: index = addr[4+IDX_W-1:4]; tag = addr[ADDR_W-1:4+IDX_W].
- Reset (rst=0 at a clock edge):
  - All valid bits cleared; FSM to IDLE; beat=0.
  - cpu_valid=0, cpu_busy=0, mem_req=0, mem_addr=0, cpu_data=0.
  - Data and tag arrays are not cleared.
  - Applies mid-refill: the partial line is discarded and mem_req drops on the next cycle.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - cpu_rd_en=1 and cpu_abort=0 latches addr, then looks up.
  - Hit (valid[index] and tag match): cpu_data = line, cpu_valid=1 in the next cycle. Latency 1. Stay in IDLE, so back-to-back hits are possible every cycle.
  - Miss: go to REFILL, cpu_busy=1 next cycle.
  - cpu_rd_en with cpu_abort=1 in the same cycle: request ignored.
- REFILL:
  - mem_req=1; mem_addr = {latched line addr, beat, 2'b00}, stable until mem_ack.
  - Each mem_ack writes mem_data into slot [beat] and increments beat.
  - The ack on beat 3 writes data, tag, and valid=1 into the array; next state is RESPOND; mem_req deasserts the cycle after the final ack.
  - mem_ack while mem_req=0: ignored.
  - cpu_rd_en: ignored.
- RESPOND:
  - cpu_valid=1 with the refilled line for one cycle; cpu_busy=0; return to IDLE.
- Abort:
  - cpu_abort in REFILL sets a drop flag. The refill still completes and the line is installed, but the RESPOND pulse is suppressed (cpu_valid stays 0).
  - cpu_abort in the cycle a hit response would appear: cpu_valid forced 0.
  - Drop flag clears on entering IDLE.
- cpu_valid is never high in two consecutive cycles for a miss. cpu_data holds its last value when cpu_valid=0.

Optional Feature:
- Macro: TOMASULO_ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], cleared by reset.
  - Each counts accepted, non-aborted lookups; wraps 0xFFFFFFFF to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package tomasulo_icache_pkg:
  - icache_state_t enum {IDLE, REFILL, RESPOND}.
  - LINE_BYTES=16, WORDS_PER_LINE=4, OFFSET_W=4.
  - line_t = logic [127:0].
- Sub-module tomasulo_icache_array:
  - Holds valid, tag, and data per line.
  - One synchronous read port: index in, {valid, tag, line} out next cycle.
  - One write port: index, tag, line, we.
  - valid_clr input driven by reset.
  - The top level holds the FSM, beat counter, and compare.

Test Plan:
- Cold miss: reset, rd_en addr 0x0000_0040; memory acks each beat after 2 cycles with words 0xA0..0xA3. Expected:
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - One cpu_valid pulse with cpu_data = {0xA3, 0xA2, 0xA1, 0xA0}.
  - cpu_busy high throughout the refill.
- Hit after fill: rd_en 0x4C (same line) the cycle after RESPOND -> cpu_valid next cycle with the same data, mem_req stays 0.
- Conflict eviction (LINES=16): fill 0x040, then request 0x140 (same index 4) -> miss and refill. A following request to 0x040 misses again.
- Abort mid-refill: cpu_abort pulsed after beat 1 ack -> all 4 beats still requested, no cpu_valid. A subsequent rd_en to the same line hits with latency 1.
- Reset mid-refill: rst=0 after beat 2 -> next cycle mem_req=0, busy=0. A re-request of the same line misses and restarts at beat 0.
- Back-to-back hits (STATS_EN defined): 3 consecutive rd_en hits -> cpu_valid high 3 consecutive cycles, hit_cnt increments by 3, miss_cnt unchanged.
